seven_seg_display_ctrl: RTL and testbench
=========================================

# seven_seg_display_ctrl

Sequencing controller for the greenhouse front-panel 4-digit seven-segment display. Accepts a binary sensor reading through a load handshake and converts it to four BCD digits with a sequential shift-add-3 engine. It then time-multiplexes the digits, presenting one 4-bit digit value per scan slot to the registered `val_to_seven_seg` decoder and driving the matching active-low digit anode. Leading zeros are blanked, and values above 9999 are clamped and flagged.

## Interface
- `DIGIT_TICKS`, default 50000: clk cycles each digit stays selected; legal range 4..2^20.
- `clk  input  1`: system clock; all logic is rising-edge.
- `reset_n  input  1`: synchronous, active-low reset.
- `load  input  1`: single-cycle request to display `value`; sampled only in IDLE.
- `value  input  14`: unsigned binary reading, 0..16383.
- `busy  output  1`: high while a conversion is in progress; `load` is ignored while high.
- `overflow  output  1`: high while the displayed number is a clamped 9999.
- `digit_value  output  4`: BCD digit feeding the decoder's `value` input.
- `anodes  output  4`: active-low digit enables; bit 0 is the least significant digit.

## Operation
- Reset (synchronous, `reset_n` low at a rising edge):
  - state = IDLE, `busy` = 0, `overflow` = 0.
  - `digit_value` = 0, `anodes` = 4'b1111.
  - Display digits = 0, scan index = 0, tick counter = 0.
  - Reset applies from any state; an in-flight conversion is discarded.
- Conversion FSM: IDLE -> CONVERT -> COMMIT -> IDLE.
  - IDLE: on `load` = 1, capture `value`; if `value` > 9999, substitute 9999 and set the pending overflow flag. Go to CONVERT with shift count 0.
  - CONVERT: exactly 14 steps, one per cycle. Each step first adds 3 to every 4-bit BCD nibble >= 5, then shifts {bcd[15:0], bin[13:0]} left by 1.
  - COMMIT: one cycle. Copy the 16-bit BCD result into the display digit registers and update `overflow` from the pending flag. Go to IDLE.
  - `load` asserted in CONVERT or COMMIT is dropped, not queued.
- Scan engine, free-running and independent of the FSM:
  - Tick counter counts 0..DIGIT_TICKS-1. On wrap, the scan index advances 0 -> 1 -> 2 -> 3 -> 0.
  - `digit_value` <= display digit[index], registered every cycle.
  - `anodes` <= one-hot-low of the index, delayed so it switches in the same cycle as the decoder output it enables.
  - Blanking: the anode for digit k is held high if digit k and all higher digits are 0, for k = 1..3. Digit 0 is never blanked, so 0 shows as "0".
- Display registers change only at COMMIT; the scan keeps showing the old number during conversion.

## Timing
- `load` sampled at edge E0 -> `busy` is high from E0 through E15 (15 cycles) and low after E15.
- New digits and `overflow` become visible after E15. The first affected `digit_value` appears after E16.
- Back-to-back loads: the earliest accepted `load` is sampled at edge E16.
- Scan index changes at edge S:
  - `digit_value` changes after S+1.
  - `anodes` changes after S+2, aligned with the decoder's one-cycle register.
- Each anode is low for exactly DIGIT_TICKS consecutive cycles per frame. Frame = 4*DIGIT_TICKS cycles.
- After reset release: `anodes` stays 4'b1111 for the first 2 cycles, then becomes 4'b1110 showing digit 0 = 0.

## Test plan
All scenarios use DIGIT_TICKS = 4.
- Reset then idle -> `anodes` cycles through 1110 for 4 cycles, then 1111 for 12 cycles (digits 1..3 blanked); `digit_value` = 0 and `busy` = 0 throughout.
- load with `value` = 1234 -> `busy` high for exactly 15 cycles. Afterwards digits 3..0 = 1,2,3,4, all anodes enabled in turn, each anode low while `digit_value` (delayed one cycle) matches its digit; `overflow` = 0.
- load with `value` = 12000 -> display shows 9999 and `overflow` = 1. A subsequent load of 7 -> `overflow` = 0, only anode 0 is ever driven low, and `digit_value` = 7 in that slot.
- load with 42, then load with 999 pulsed 5 cycles later while `busy` = 1 -> the second load is ignored and the display settles on 42 (anodes 0 and 1 only).
- `reset_n` low during CONVERT, 7 cycles after a load of 5000 -> on the next edge `busy` = 0, the display returns to "0", and no commit occurs.
- Boundary values 0, 9, 10, 9999, 10000 -> digits 0000, 0009, 0010, 9999, 9999 (with `overflow` = 1 for 10000), each with correct leading-zero blanking.

Source files
------------

// File: rtl/seven_seg_display_ctrl.sv
// seven_seg_display_ctrl
// Loads a 14-bit reading, converts it to four BCD digits with a sequential
// shift-add-3 engine, and time-multiplexes the digits onto a registered
// seven-segment decoder with active-low anodes and leading-zero blanking.
// Readings above 9999 are clamped to 9999 and flagged with overflow.
module seven_seg_display_ctrl #(
    parameter int DIGIT_TICKS = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [13:0] value,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  digit_value,
    output logic [3:0]  anodes
);

    localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [13:0] MAX_SHOWN = 14'd9999;
    localparam logic [3:0]  LAST_STEP = 4'd13;

    // conversion datapath
    logic [1:0]  state_reg;
    logic [15:0] bcd_reg;
    logic [13:0] bin_reg;
    logic [3:0]  step_reg;
    logic        ovf_pending_reg;
    logic [15:0] bcd_adj;
    logic [29:0] shifted;

    // display and scan
    logic [15:0]       disp_reg;
    logic [TICK_W-1:0] tick_reg;
    logic [1:0]        idx_reg;
    logic [1:0]        idx_d_reg;
    logic              en_d_reg;
    logic [3:0]        blank_vec;

    genvar gi;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_reg[gi*4 +: 4] + 4'd3) :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_reg} << 1;

    // A digit is blank when it and every more significant digit are zero;
    // the units digit always shows so that zero reads as "0"
    assign blank_vec[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_blank
            assign blank_vec[gi] = (disp_reg[15:gi*4] == '0);
        end
    endgenerate

    assign busy = (state_reg != ST_IDLE);

    // Conversion FSM: capture/clamp, 14 shift-add-3 steps, then commit to display
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            bcd_reg         <= '0;
            bin_reg         <= '0;
            step_reg        <= '0;
            ovf_pending_reg <= 1'b0;
            disp_reg        <= '0;
            overflow        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        bin_reg         <= (value > MAX_SHOWN) ? MAX_SHOWN : value;
                        ovf_pending_reg <= (value > MAX_SHOWN);
                        bcd_reg         <= '0;
                        step_reg        <= '0;
                        state_reg       <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_reg  <= shifted[29:14];
                    bin_reg  <= shifted[13:0];
                    step_reg <= step_reg + 4'd1;
                    if (step_reg == LAST_STEP) begin
                        state_reg <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_reg  <= bcd_reg;
                    overflow  <= ovf_pending_reg;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running scan; anode enable trails digit_value by one cycle so it
    // lines up with the decoder's output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_reg    <= '0;
            idx_reg     <= 2'd0;
            idx_d_reg   <= 2'd0;
            en_d_reg    <= 1'b0;
            digit_value <= 4'd0;
            anodes      <= 4'b1111;
        end else begin
            if (tick_reg == TICK_LAST) begin
                tick_reg <= '0;
                idx_reg  <= idx_reg + 2'd1;
            end else begin
                tick_reg <= tick_reg + TICK_ONE;
            end
            digit_value <= disp_reg[{idx_reg, 2'b00} +: 4];
            idx_d_reg   <= idx_reg;
            en_d_reg    <= ~blank_vec[idx_reg];
            anodes      <= en_d_reg ? ~(4'b0001 << idx_d_reg) : 4'b1111;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Testbench for seven_seg_display_ctrl (DIGIT_TICKS = 4).
// Stimulus pushes the expected committed number into a queue; a monitor
// pops it when busy falls and checks every cycle of the scan against a
// number-level model (digit k = (N / 10^k) % 10, shown iff k == 0 or N >= 10^k).
module tb_seven_seg_display_ctrl;

    localparam int DT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = '0;
    logic        busy;
    logic        overflow;
    logic [3:0]  digit_value;
    logic [3:0]  anodes;

    typedef struct {
        int num;
        bit ovf;
        int accept;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    bit   started = 1'b0;

    seven_seg_display_ctrl #(.DIGIT_TICKS(DT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .value       (value),
        .busy        (busy),
        .overflow    (overflow),
        .digit_value (digit_value),
        .anodes      (anodes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, act, exp_v);
        end
    endtask

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int dec_digit(input int num, input int k);
        return (num / pow10(k)) % 10;
    endfunction

    function automatic int slot(input int m);
        return (m / DT) % 4;
    endfunction

    function automatic int exp_anodes(input int num, input int k);
        if (k == 0 || num >= pow10(k)) return (~(1 << k)) & 15;
        return 15;
    endfunction

    // Monitor / scoreboard: sampled 1 time unit after each rising edge
    initial begin : monitor
        int   disp_now;
        int   disp_1;
        int   disp_2;
        bit   ovf_m;
        bit   busy_prev;
        int   exp_busy;
        exp_t e;
        disp_now = 0; disp_1 = 0; disp_2 = 0; ovf_m = 0; busy_prev = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                started   = 1'b1;
                edge_n    = 0;
                disp_now  = 0; disp_1 = 0; disp_2 = 0;
                ovf_m     = 0;
                busy_prev = 0;
                exp_q.delete();
                chk("reset_busy", busy, 0);
                chk("reset_overflow", overflow, 0);
                chk("reset_digit_value", digit_value, 0);
                chk("reset_anodes", anodes, 15);
            end else if (started) begin
                edge_n++;
                disp_2 = disp_1;
                disp_1 = disp_now;
                if (busy_prev && !busy) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL commit_without_load at edge %0d: busy fell, no load pending", edge_n);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_cycles", edge_n - e.accept, 15);
                        $display("commit value=%0d overflow=%0d accepted_edge=%0d commit_edge=%0d",
                                 e.num, e.ovf, e.accept, edge_n);
                        disp_now = e.num;
                        ovf_m    = e.ovf;
                    end
                end
                if (exp_q.size() > 0 && edge_n > exp_q[0].accept + 20) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_timeout at edge %0d: load of %0d never committed",
                             edge_n, exp_q[0].num);
                    void'(exp_q.pop_front());
                end
                exp_busy = (exp_q.size() > 0 && edge_n >= exp_q[0].accept &&
                            edge_n < exp_q[0].accept + 15) ? 1 : 0;
                chk("busy", busy, exp_busy);
                chk("overflow", overflow, ovf_m);
                chk("digit_value", digit_value, dec_digit(disp_1, slot(edge_n - 1)));
                if (edge_n < 2)
                    chk("anodes", anodes, 15);
                else
                    chk("anodes", anodes, exp_anodes(disp_2, slot(edge_n - 2)));
                busy_prev = busy;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v, input bit expect_accept);
        exp_t e;
        @(negedge clk);
        load  = 1'b1;
        value = 14'(v);
        if (expect_accept) begin
            e.num    = (v > 9999) ? 9999 : v;
            e.ovf    = (v > 9999);
            e.accept = edge_n + 1;
            exp_q.push_back(e);
        end
        $display("load value=%0d expect_accept=%0d edge=%0d", v, expect_accept, edge_n + 1);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin : stimulus
        int bvals[5];
        int v;
        bvals = '{0, 9, 10, 9999, 10000};

        idle(3);
        reset_n = 1'b1;
        idle(20);

        do_load(1234, 1'b1);
        idle(35);

        do_load(12000, 1'b1);
        idle(35);
        do_load(7, 1'b1);
        idle(35);

        // second load while busy is dropped
        do_load(42, 1'b1);
        idle(4);
        do_load(999, 1'b0);
        idle(35);

        // reset sampled 7 edges after the load discards the conversion
        do_load(5000, 1'b1);
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(20);

        foreach (bvals[i]) begin
            do_load(bvals[i], 1'b1);
            idle(35);
        end

        // load in COMMIT is dropped; next-cycle load is accepted
        do_load(321, 1'b1);
        idle(13);
        do_load(8888, 1'b0);
        do_load(56, 1'b1);
        idle(14);
        do_load(4321, 1'b1);
        idle(35);

        repeat (12) begin
            if ($urandom_range(0, 3) == 0)
                v = $urandom_range(0, 99);
            else
                v = $urandom_range(0, 16383);
            do_load(v, 1'b1);
            idle(14 + $urandom_range(0, 40));
        end

        idle(40);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
